// File: rtl/ray_marcher_frame.sv
`timescale 1ns/1ps
// ray_marcher_frame: fixed-point ray-marching frame renderer.
// Renders DISPLAY_WIDTH x DISPLAY_HEIGHT pixels in raster order, NUM_CORES
// lock-step lanes per batch, and streams one shade per pixel.
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   pos_vec_in, dir_vec_in         camera position / base direction {x,y,z} Q16.16
//   toggle_checker_in              enable checker darkening
//   toggle_dither_in               enable 2x2 dither
//   fractal_sel_in                 scene select
//   hcount_out, vcount_out         pixel coordinates (valid with valid_out)
//   color_out                      4-bit shade
//   valid_out                      high during each pixel output cycle
//   new_frame_out                  one-cycle pulse after the last pixel of a frame
module ray_marcher_frame #(
  parameter int unsigned DISPLAY_WIDTH  = 320,
  parameter int unsigned DISPLAY_HEIGHT = 240,
  parameter int unsigned H_BITS         = 9,
  parameter int unsigned V_BITS         = 8,
  parameter int unsigned COLOR_BITS     = 4,
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned MAX_ITERS      = 16,
  parameter int unsigned UV_SHIFT       = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [95:0]           pos_vec_in,
  input  logic [95:0]           dir_vec_in,
  input  logic                  toggle_checker_in,
  input  logic                  toggle_dither_in,
  input  logic [2:0]            fractal_sel_in,
  output logic [H_BITS-1:0]     hcount_out,
  output logic [V_BITS-1:0]     vcount_out,
  output logic [COLOR_BITS-1:0] color_out,
  output logic                  valid_out,
  output logic                  new_frame_out
);

  localparam int unsigned IT_W  = (MAX_ITERS > 1) ? $clog2(MAX_ITERS) : 1;
  localparam int unsigned LN_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned UV_UP = 16 - UV_SHIFT;

  localparam logic signed [31:0] Q_ONE   = 32'sh0001_0000;
  localparam logic signed [31:0] Q_HALF  = 32'sh0000_8000;
  localparam logic signed [31:0] HIT_EPS = 32'sd256;

  localparam logic [H_BITS-1:0] LAST_H0   = H_BITS'(DISPLAY_WIDTH - NUM_CORES);
  localparam logic [V_BITS-1:0] LAST_V    = V_BITS'(DISPLAY_HEIGHT - 1);
  localparam logic [IT_W-1:0]   LAST_IT   = IT_W'(MAX_ITERS - 1);
  localparam logic [LN_W-1:0]   LAST_LANE = LN_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_MARCH,
    S_OUTPUT,
    S_NEWFRAME
  } state_t;

  state_t              state_q, state_n;
  logic [H_BITS-1:0]   h0_q, h0_n;
  logic [V_BITS-1:0]   v_q, v_n;
  logic [IT_W-1:0]     iter_q, iter_n;
  logic [LN_W-1:0]     lane_q, lane_n;

  logic [95:0]         pos_q, dir_q;
  logic [2:0]          sel_q;
  logic                chk_q, dith_q;
  logic                first_batch_c;
  logic [95:0]         pos_src_c, dir_src_c;

  logic [NUM_CORES-1:0][31:0]     px_q, py_q, pz_q, rx_q, ry_q, rz_q;
  logic [NUM_CORES-1:0][31:0]     px_n, py_n, pz_n, rx_n, ry_n, rz_n;
  logic [NUM_CORES-1:0]           hit_q, hit_n;
  logic [NUM_CORES-1:0][IT_W-1:0] hit_it_q, hit_it_n;

  logic [31:0]        u_c [NUM_CORES];
  logic [31:0]        vp_c;
  logic signed [31:0] dist_c [NUM_CORES];
  logic signed [63:0] prod_x [NUM_CORES];
  logic signed [63:0] prod_y [NUM_CORES];
  logic signed [63:0] prod_z [NUM_CORES];

  logic [H_BITS-1:0]     hc_n;
  logic                  sh_hit;
  logic [IT_W-1:0]       sh_it;
  logic                  sh_chk_bit;
  logic [15:0]           twice_it, s5, shade_sum, shade_half;
  logic [COLOR_BITS-1:0] color_n;

  // Scene distance: box+floor, octahedron, or floor only.
  function automatic logic signed [31:0] dist_f(input logic signed [31:0] x,
                                                input logic signed [31:0] y,
                                                input logic signed [31:0] z,
                                                input logic [2:0]         sel);
    logic signed [31:0] ax, ay1, az, y1, m;
    y1  = y - Q_ONE;
    ax  = (x < 0)  ? -x  : x;
    ay1 = (y1 < 0) ? -y1 : y1;
    az  = (z < 0)  ? -z  : z;
    m   = (ax > ay1) ? ax : ay1;
    m   = (m > az) ? m : az;
    m   = m - Q_HALF;
    case (sel)
      3'd1:    dist_f = ax + ay1 + az - Q_ONE;
      3'd2:    dist_f = y;
      default: dist_f = (m < y) ? m : y;
    endcase
  endfunction

  // Frame inputs are taken live at batch 0 and from the latched copy afterwards.
  assign first_batch_c = (h0_q == '0) && (v_q == '0);
  assign pos_src_c     = first_batch_c ? pos_vec_in : pos_q;
  assign dir_src_c     = first_batch_c ? dir_vec_in : dir_q;
  assign vp_c          = (32'(DISPLAY_HEIGHT / 2) - 32'(v_q)) << UV_UP;

  // Per-lane pixel offset, distance and ray*d step (product bits [47:16]).
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
    assign u_c[k]    = (32'(h0_q) + 32'(k) - 32'(DISPLAY_WIDTH / 2)) << UV_UP;
    assign dist_c[k] = dist_f($signed(px_q[k]), $signed(py_q[k]), $signed(pz_q[k]), sel_q);
    assign prod_x[k] = 64'($signed(rx_q[k])) * 64'(dist_c[k]);
    assign prod_y[k] = 64'($signed(ry_q[k])) * 64'(dist_c[k]);
    assign prod_z[k] = 64'($signed(rz_q[k])) * 64'(dist_c[k]);
  end

  // Batch sequencer state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_LOAD;
      h0_q    <= '0;
      v_q     <= '0;
      iter_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_n;
      h0_q    <= h0_n;
      v_q     <= v_n;
      iter_q  <= iter_n;
      lane_q  <= lane_n;
    end
  end

  // Batch sequencer next state: LOAD -> MARCH x MAX_ITERS -> OUTPUT x NUM_CORES.
  always_comb begin
    state_n = state_q;
    h0_n    = h0_q;
    v_n     = v_q;
    iter_n  = iter_q;
    lane_n  = lane_q;
    unique case (state_q)
      S_LOAD: begin
        state_n = S_MARCH;
        iter_n  = '0;
      end
      S_MARCH: begin
        if (iter_q == LAST_IT) begin
          state_n = S_OUTPUT;
          lane_n  = '0;
        end else begin
          iter_n = iter_q + IT_W'(1);
        end
      end
      S_OUTPUT: begin
        if (lane_q == LAST_LANE) begin
          lane_n = '0;
          if (h0_q == LAST_H0) begin
            h0_n = '0;
            if (v_q == LAST_V) begin
              v_n     = '0;
              state_n = S_NEWFRAME;
            end else begin
              v_n     = v_q + V_BITS'(1);
              state_n = S_LOAD;
            end
          end else begin
            h0_n    = h0_q + H_BITS'(NUM_CORES);
            state_n = S_LOAD;
          end
        end else begin
          lane_n = lane_q + LN_W'(1);
        end
      end
      S_NEWFRAME: state_n = S_LOAD;
      default:    state_n = S_LOAD;
    endcase
  end

  // Lane next values: init at LOAD, one march step per MARCH cycle, else hold.
  always_comb begin
    px_n     = px_q;
    py_n     = py_q;
    pz_n     = pz_q;
    rx_n     = rx_q;
    ry_n     = ry_q;
    rz_n     = rz_q;
    hit_n    = hit_q;
    hit_it_n = hit_it_q;
    case (state_q)
      S_LOAD: begin
        for (int k = 0; k < NUM_CORES; k++) begin
          px_n[k]     = pos_src_c[95:64];
          py_n[k]     = pos_src_c[63:32];
          pz_n[k]     = pos_src_c[31:0];
          rx_n[k]     = dir_src_c[95:64] + u_c[k];
          ry_n[k]     = dir_src_c[63:32] + vp_c;
          rz_n[k]     = dir_src_c[31:0];
          hit_n[k]    = 1'b0;
          hit_it_n[k] = '0;
        end
      end
      S_MARCH: begin
        for (int k = 0; k < NUM_CORES; k++) begin
          if (!hit_q[k]) begin
            if (dist_c[k] < HIT_EPS) begin
              hit_n[k]    = 1'b1;
              hit_it_n[k] = iter_q;
            end else begin
              px_n[k] = px_q[k] + 32'(prod_x[k] >>> 16);
              py_n[k] = py_q[k] + 32'(prod_y[k] >>> 16);
              pz_n[k] = pz_q[k] + 32'(prod_z[k] >>> 16);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Shade of the lane about to be presented (uses next-values so the final
  // march iteration is visible to lane 0).
  always_comb begin
    hc_n       = h0_q + H_BITS'(lane_n);
    sh_hit     = hit_n[lane_n];
    sh_it      = hit_it_n[lane_n];
    sh_chk_bit = px_n[lane_n][16] ^ pz_n[lane_n][16];
    twice_it   = 16'(sh_it) << 1;
    s5         = '0;
    if (sh_hit && (twice_it < 16'd31)) s5 = 16'd31 - twice_it;
    shade_sum  = s5;
    if (dith_q) shade_sum = s5 + 16'(hc_n[0] ^ v_q[0]);
    shade_half = shade_sum >> 1;
    color_n    = (shade_half > 16'd15) ? COLOR_BITS'(15) : COLOR_BITS'(shade_half);
    if (chk_q && sh_hit && sh_chk_bit) color_n = color_n >> 1;
  end

  // Lane state, frame-constant inputs and registered pixel outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      px_q          <= '0;
      py_q          <= '0;
      pz_q          <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      rz_q          <= '0;
      hit_q         <= '0;
      hit_it_q      <= '0;
      pos_q         <= '0;
      dir_q         <= '0;
      sel_q         <= '0;
      chk_q         <= 1'b0;
      dith_q        <= 1'b0;
      hcount_out    <= '0;
      vcount_out    <= '0;
      color_out     <= '0;
      valid_out     <= 1'b0;
      new_frame_out <= 1'b0;
    end else begin
      px_q     <= px_n;
      py_q     <= py_n;
      pz_q     <= pz_n;
      rx_q     <= rx_n;
      ry_q     <= ry_n;
      rz_q     <= rz_n;
      hit_q    <= hit_n;
      hit_it_q <= hit_it_n;
      if ((state_q == S_LOAD) && first_batch_c) begin
        pos_q  <= pos_vec_in;
        dir_q  <= dir_vec_in;
        sel_q  <= fractal_sel_in;
        chk_q  <= toggle_checker_in;
        dith_q <= toggle_dither_in;
      end
      valid_out     <= (state_n == S_OUTPUT);
      new_frame_out <= (state_n == S_NEWFRAME);
      if (state_n == S_OUTPUT) begin
        hcount_out <= hc_n;
        vcount_out <= v_q;
        color_out  <= color_n;
      end
    end
  end

endmodule

// File: tb/tb_ray_marcher_frame.sv
`timescale 1ns/1ps
// Self-checking bench for ray_marcher_frame on an 8x4 frame with 2 lanes.
module tb_ray_marcher_frame;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int N     = 2;
  localparam int MI    = 16;
  localparam int UVS   = 8;
  localparam int BATCH = 1 + MI + N;
  localparam int NPIX  = W * H;
  localparam int NF_CYC    = (NPIX / N) * BATCH;
  localparam int FRAME_CYC = NF_CYC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] pos_vec, dir_vec;
  logic        chk_tog, dith_tog;
  logic [2:0]  fractal_sel;
  logic [8:0]  hcount;
  logic [7:0]  vcount;
  logic [3:0]  color;
  logic        valid, new_frame;

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint nf_abs;
  int     obs[NPIX];
  int     ref0[NPIX];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ray_marcher_frame #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(9), .V_BITS(8),
    .COLOR_BITS(4), .NUM_CORES(N), .MAX_ITERS(MI), .UV_SHIFT(UVS)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .pos_vec_in(pos_vec), .dir_vec_in(dir_vec),
    .toggle_checker_in(chk_tog), .toggle_dither_in(dith_tog),
    .fractal_sel_in(fractal_sel),
    .hcount_out(hcount), .vcount_out(vcount), .color_out(color),
    .valid_out(valid), .new_frame_out(new_frame)
  );

  // ---------------- reference model ----------------
  function automatic int q_abs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int q_mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  function automatic int scene_dist(input int x, input int y, input int z, input int sel);
    int m;
    if (sel == 1) return q_abs(x) + q_abs(y - 65536) + q_abs(z) - 65536;
    if (sel == 2) return y;
    m = q_abs(x);
    if (q_abs(y - 65536) > m) m = q_abs(y - 65536);
    if (q_abs(z) > m) m = q_abs(z);
    m = m - 32768;
    return (m < y) ? m : y;
  endfunction

  function automatic int model_color(input int h, input int v, input int sel, input bit chk,
                                     input bit dith, input logic [95:0] pos, input logic [95:0] dir);
    int px, py, pz, rx, ry, rz, d, hit_it, s5, col;
    bit hit;
    px = $signed(pos[95:64]); py = $signed(pos[63:32]); pz = $signed(pos[31:0]);
    rx = $signed(dir[95:64]) + (h - W / 2) * (1 << (16 - UVS));
    ry = $signed(dir[63:32]) + (H / 2 - v) * (1 << (16 - UVS));
    rz = $signed(dir[31:0]);
    hit = 0; hit_it = 0;
    for (int i = 0; i < MI; i++) begin
      if (!hit) begin
        d = scene_dist(px, py, pz, sel);
        if (d < 256) begin
          hit = 1; hit_it = i;
        end else begin
          px = px + q_mul(rx, d); py = py + q_mul(ry, d); pz = pz + q_mul(rz, d);
        end
      end
    end
    s5 = hit ? ((31 - 2 * hit_it > 0) ? 31 - 2 * hit_it : 0) : 0;
    col = dith ? (s5 + ((h % 2) ^ (v % 2))) / 2 : s5 / 2;
    if (col > 15) col = 15;
    if (chk && hit && ((((px >> 16) ^ (pz >> 16)) & 1) == 1)) col = col / 2;
    return col;
  endfunction

  // ---------------- frame checker ----------------
  // Called at the falling edge of a batch-0 LOAD cycle; returns at the falling
  // edge of the next frame's LOAD cycle (or on timeout).
  task automatic check_frame(input string tag, input int chg_at, input logic [2:0] chg_sel);
    int exp_col[NPIX];
    int npix, nf_c, ecyc;
    bit nf_valid;
    npix = 0; nf_c = -1; nf_valid = 0;
    for (int p = 0; p < NPIX; p++)
      exp_col[p] = model_color(p % W, p / W, int'(fractal_sel), chk_tog, dith_tog, pos_vec, dir_vec);
    for (int c = 1; c <= NF_CYC + 20; c++) begin
      @(negedge clk);
      if (c == chg_at) fractal_sel = chg_sel;
      if (valid) begin
        if (npix >= NPIX) begin
          n_cmp++; n_err++;
          $display("FAIL %s extra_pixel: got pixel %0d at cycle %0d, want none", tag, npix, c);
        end else begin
          ecyc = (npix / N) * BATCH + 1 + MI + (npix % N);
          obs[npix] = int'(color);
          n_cmp++;
          if (c !== ecyc) begin
            n_err++; $display("FAIL %s pix%0d cycle: got %0d want %0d", tag, npix, c, ecyc);
          end
          n_cmp++;
          if (int'(hcount) !== npix % W || int'(vcount) !== npix / W) begin
            n_err++;
            $display("FAIL %s pix%0d coord: got (%0d,%0d) want (%0d,%0d)", tag, npix,
                     hcount, vcount, npix % W, npix / W);
          end
          n_cmp++;
          if (int'(color) !== exp_col[npix]) begin
            n_err++; $display("FAIL %s pix%0d color: got %0d want %0d", tag, npix, color, exp_col[npix]);
          end
        end
        npix++;
      end
      if (new_frame) begin
        nf_c = c; nf_valid = valid; nf_abs = cyc;
        break;
      end
    end
    n_cmp++;
    if (nf_c !== NF_CYC) begin
      n_err++; $display("FAIL %s new_frame_cycle: got %0d want %0d", tag, nf_c, NF_CYC);
    end
    n_cmp++;
    if (npix !== NPIX) begin
      n_err++; $display("FAIL %s pixel_count: got %0d want %0d", tag, npix, NPIX);
    end
    n_cmp++;
    if (nf_valid !== 1'b0) begin
      n_err++; $display("FAIL %s valid_at_new_frame: got %0d want 0", tag, nf_valid);
    end
    if (nf_c >= 0) begin
      @(negedge clk);
      n_cmp++;
      if (new_frame !== 1'b0 || valid !== 1'b0) begin
        n_err++; $display("FAIL %s pulse_width: got nf=%0d valid=%0d want 0/0", tag, new_frame, valid);
      end
    end
  endtask

  task automatic set_base(input logic [2:0] sel, input bit chk, input bit dith);
    pos_vec     = {32'sh0000_0000, 32'sh0001_0000, 32'shFFFE_8000};
    dir_vec     = {32'sh0000_0000, 32'sh0000_0000, 32'sh0001_0000};
    fractal_sel = sel;
    chk_tog     = chk;
    dith_tog    = dith;
  endtask

  task automatic check_pix(input string tag, input int h, input int v, input int want);
    n_cmp++;
    if (obs[v * W + h] !== want) begin
      n_err++; $display("FAIL %s (%0d,%0d) color: got %0d want %0d", tag, h, v, obs[v * W + h], want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_base(3'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (hcount !== '0 || vcount !== '0 || color !== '0 || valid !== 1'b0 || new_frame !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got h=%0d v=%0d c=%0d valid=%0d nf=%0d want all 0",
               hcount, vcount, color, valid, new_frame);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_timing();
    longint nf1;
    check_frame("base", -1, 3'd0);
    nf1 = nf_abs;
    check_pix("base", 4, 2, 14);
    for (int p = 0; p < NPIX; p++) ref0[p] = obs[p];
    check_frame("base2", -1, 3'd0);
    n_cmp++;
    if (nf_abs - nf1 !== longint'(FRAME_CYC)) begin
      n_err++; $display("FAIL frame_period: got %0d want %0d", nf_abs - nf1, FRAME_CYC);
    end
  endtask

  task automatic test_dither();
    set_base(3'd0, 1'b0, 1'b1);
    check_frame("dither", -1, 3'd0);
    check_pix("dither", 4, 2, 14);
    check_pix("dither", 5, 2, 15);
  endtask

  task automatic test_checker();
    set_base(3'd0, 1'b1, 1'b0);
    check_frame("checker", -1, 3'd0);
    check_pix("checker", 4, 2, 7);
  endtask

  task automatic test_scene_sel();
    set_base(3'd2, 1'b0, 1'b0);
    check_frame("sel2", -1, 3'd0);
    check_pix("sel2", 4, 2, 0);
    set_base(3'd5, 1'b0, 1'b0);
    check_frame("sel5", -1, 3'd0);
    for (int p = 0; p < NPIX; p++) begin
      n_cmp++;
      if (obs[p] !== ref0[p]) begin
        n_err++; $display("FAIL sel5_alias pix%0d: got %0d want %0d", p, obs[p], ref0[p]);
      end
    end
  endtask

  task automatic test_midframe_sel();
    set_base(3'd0, 1'b0, 1'b0);
    check_frame("sel_hold", 50, 3'd2);
    check_pix("sel_hold", 4, 2, 14);
    check_frame("sel_next", -1, 3'd0);
    check_pix("sel_next", 4, 2, 0);
  endtask

  task automatic test_midframe_reset();
    bit saw_nf;
    saw_nf = 0;
    set_base(3'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 5 * BATCH + 1 + 8; c++) begin
      @(negedge clk);
      if (new_frame) saw_nf = 1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (new_frame) saw_nf = 1;
    end
    n_cmp++;
    if (valid !== 1'b0 || hcount !== '0 || vcount !== '0 || color !== '0) begin
      n_err++; $display("FAIL midreset_outputs: got valid=%0d h=%0d v=%0d c=%0d want 0", valid, hcount, vcount, color);
    end
    n_cmp++;
    if (saw_nf !== 1'b0) begin
      n_err++; $display("FAIL midreset_no_pulse: got %0d want 0", saw_nf);
    end
    rst = 1'b0;
    check_frame("after_rst", -1, 3'd0);
  endtask

  task automatic test_random();
    int x, y, z;
    for (int f = 0; f < 6; f++) begin
      fractal_sel = 3'($urandom_range(0, 7));
      chk_tog     = 1'($urandom_range(0, 1));
      dith_tog    = 1'($urandom_range(0, 1));
      x = int'($urandom_range(0, 65535)) - 32768;
      y = 65536 + int'($urandom_range(0, 16383)) - 8192;
      z = -98304 + int'($urandom_range(0, 32767)) - 16384;
      pos_vec = {32'(x), 32'(y), 32'(z)};
      x = int'($urandom_range(0, 8191)) - 4096;
      y = int'($urandom_range(0, 8191)) - 4096;
      z = 65536 + int'($urandom_range(0, 16383)) - 8192;
      dir_vec = {32'(x), 32'(y), 32'(z)};
      check_frame("random", -1, 3'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_base(3'd0, 1'b0, 1'b0);
    test_reset();
    test_frame_timing();
    test_dither();
    test_checker();
    test_scene_sel();
    test_midframe_sel();
    test_midframe_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
